// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of decode,
// buffers {pc, instr} pairs, and flushes/refetches on redirect.
module fetch_prefetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0200,
   parameter int          DEPTH    = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic [31:0]              iaddr,
   output logic                     iren,
   input  logic                     ibusy,
   input  logic [31:0]              irdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [31:0]              instr,
   output logic [31:0]              pc,
   output logic                     instr_valid,
   input  logic                     deq_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0]   NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DISCARD
   } state_t;

   state_t          state;
   logic [31:0]     fetch_pc;
   logic [31:0]     req_addr;
   logic [31:0]     rpc_al;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count_nxt;
   logic            push;
   logic            pop;

   logic [31:0]     mem_pc    [DEPTH];
   logic [31:0]     mem_instr [DEPTH];

   assign rpc_al      = redirect_pc & ~32'h3;
   assign iaddr       = req_addr;
   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? mem_instr[head] : NOP;
   assign pc          = instr_valid ? mem_pc[head] : fetch_pc;

   // Push on a live completion, pop on consume; redirect cancels both.
   always_comb begin
      push      = (state == S_BUSY) && !ibusy && !redirect;
      pop       = instr_valid && deq_ready && !redirect;
      count_nxt = count;
      if (redirect)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CW'(1);
      else if (pop && !push)
         count_nxt = count - CW'(1);
   end

   // Request FSM; a request is only issued with a queue slot reserved.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         iren     <= 1'b0;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (redirect) begin
                  fetch_pc <= rpc_al;
               end else if (count < FULL) begin
                  state    <= S_BUSY;
                  iren     <= 1'b1;
                  req_addr <= fetch_pc;
               end
            end
            S_BUSY: begin
               if (redirect) begin
                  fetch_pc <= rpc_al;
                  if (ibusy) begin
                     state <= S_DISCARD;
                  end else begin
                     state <= S_IDLE;
                     iren  <= 1'b0;
                  end
               end else if (!ibusy) begin
                  fetch_pc <= req_addr + 32'd4;
                  if (count_nxt < FULL) begin
                     req_addr <= req_addr + 32'd4;
                  end else begin
                     state <= S_IDLE;
                     iren  <= 1'b0;
                  end
               end
            end
            S_DISCARD: begin
               if (redirect)
                  fetch_pc <= rpc_al;
               if (!ibusy) begin
                  state <= S_IDLE;
                  iren  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               iren  <= 1'b0;
            end
         endcase
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (redirect) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (pop)
               head <= head + AW'(1);
            if (push)
               tail <= tail + AW'(1);
         end
         count <= count_nxt;
      end
   end

   // Entry storage; written only on a live push.
   always_ff @(posedge CLK) begin
      if (!RST && push) begin
         mem_pc[tail]    <= req_addr;
         mem_instr[tail] <= irdata;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based
// reference model of the fetch/flush behaviour.
module tb_fetch_prefetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0200;
   localparam int          NPH   = 8;
   localparam int          CYC   = 500;

   logic        CLK;
   logic        RST;
   logic [31:0] iaddr;
   logic        iren;
   logic        ibusy;
   logic [31:0] irdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        deq_ready;
   logic [2:0]  count;

   fetch_prefetch_queue #(
      .RESET_PC(RPC),
      .DEPTH(DEPTH)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .iaddr(iaddr),
      .iren(iren),
      .ibusy(ibusy),
      .irdata(irdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .instr(instr),
      .pc(pc),
      .instr_valid(instr_valid),
      .deq_ready(deq_ready),
      .count(count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign irdata = mem_word(iaddr);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_fetch;
   logic [31:0] m_req_addr;
   int          m_req;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Next-state of the model from the inputs currently driven.
   task automatic step_model();
      int   pre;
      ent_t e;
      if (RST) begin
         q.delete();
         m_fetch    = RPC;
         m_req_addr = RPC;
         m_req      = 0;
      end else if (redirect) begin
         q.delete();
         m_fetch = redirect_pc & ~32'h3;
         m_req   = (m_req != 0 && ibusy) ? 2 : 0;
      end else begin
         pre = q.size();
         if (pre > 0 && deq_ready)
            void'(q.pop_front());
         if (m_req == 0) begin
            if (pre < DEPTH) begin
               m_req      = 1;
               m_req_addr = m_fetch;
            end
         end else if (m_req == 1) begin
            if (!ibusy) begin
               e.pc  = m_req_addr;
               e.ins = mem_word(m_req_addr);
               q.push_back(e);
               m_fetch = m_req_addr + 32'd4;
               if (q.size() < DEPTH)
                  m_req_addr = m_req_addr + 32'd4;
               else
                  m_req = 0;
            end
         end else if (!ibusy) begin
            m_req = 0;
         end
      end
   endtask

   task automatic compare();
      check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
      check("count", 32'(count), 32'(q.size()));
      check("instr", instr, q.size() != 0 ? q[0].ins : 32'h13);
      check("pc", pc, q.size() != 0 ? q[0].pc : m_fetch);
      check("iren", 32'(iren), 32'(m_req != 0));
      if (m_req != 0)
         check("iaddr", iaddr, m_req_addr);
   endtask

   int busy_pct [NPH] = '{0, 0, 60, 40, 70, 0, 50, 30};
   int deq_pct  [NPH] = '{100, 10, 50, 70, 60, 100, 50, 30};
   int red_pct  [NPH] = '{0, 0, 0, 8, 15, 10, 5, 10};
   int rst_pct  [NPH] = '{0, 0, 0, 0, 0, 0, 2, 1};

   initial begin
      int sel;
      RST         = 1'b1;
      ibusy       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      deq_ready   = 1'b0;
      m_fetch     = RPC;
      m_req_addr  = RPC;
      m_req       = 0;
      for (int ph = 0; ph < NPH; ph++) begin
         for (int c = 0; c < CYC; c++) begin
            if (ph == 0 && c < 3)
               RST = 1'b1;
            else
               RST = ($urandom_range(0, 99) < rst_pct[ph]);
            ibusy     = ($urandom_range(0, 99) < busy_pct[ph]);
            deq_ready = ($urandom_range(0, 99) < deq_pct[ph]);
            redirect  = ($urandom_range(0, 99) < red_pct[ph]);
            sel = int'($urandom_range(0, 3));
            if (sel == 0)
               redirect_pc = 32'hFFFF_FFFC;
            else if (sel == 1)
               redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
               redirect_pc = $urandom;
            step_model();
            @(posedge CLK);
            @(negedge CLK);
            compare();
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
